// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_pkg: shared types and constants for the bit-serial adder.
//   state_t    : sequencer state, 2-bit encoding {IDLE, RUN, DONE}
//   WIDTH_MIN  : smallest supported operand width
//   WIDTH_MAX  : largest supported operand width
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle between a requester and
// serial_add_ctrl.
//   start            requester -> ctrl   request, honoured only when idle
//   A, B             requester -> ctrl   operands, sampled on accept
//   sub              requester -> ctrl   subtract select (SERIAL_SUB_EN only)
//   busy, done       ctrl -> requester   status / one-cycle result strobe
//   Sum, CarryOut, Ovfl ctrl -> requester result, held until next accept
// Optional feature macro: SERIAL_SUB_EN adds the sub signal.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             CarryOut;
  logic             Ovfl;

  modport master (
    output start, A, B,
`ifdef SERIAL_SUB_EN
    output sub,
`endif
    input  busy, done, Sum, CarryOut, Ovfl
  );

  modport slave (
    input  start, A, B,
`ifdef SERIAL_SUB_EN
    input  sub,
`endif
    output busy, done, Sum, CarryOut, Ovfl
  );
endinterface

// File: rtl/serial_add_ctrl_full_adder_1bit.sv
// full_adder_1bit: the single shared arithmetic cell of the serial adder.
//   A, B, CarryIn  in   operand bits and incoming carry
//   Sum, CarryOut  out  sum bit and outgoing carry
module full_adder_1bit (
  input  logic A,
  input  logic B,
  input  logic CarryIn,
  output logic Sum,
  output logic CarryOut
);
  logic axb;

  assign axb      = A ^ B;
  assign Sum      = axb ^ CarryIn;
  assign CarryOut = (A & B) | (CarryIn & axb);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. One full adder cell is reused
// WIDTH times, operands shifted LSB-first with the carry held in a flop.
//   clk   in   clock, posedge
//   rst   in   synchronous active-high reset; aborts any operation in flight
//   bus   slave modport of serial_add_ctrl_if (start/A/B[/sub] in,
//         busy/done/Sum/CarryOut/Ovfl out)
// Timing: start accepted in cycle 0 -> done pulses in cycle WIDTH+1;
// busy covers RUN and DONE (WIDTH+1 cycles). Starts while busy are dropped.
// Optional feature macro: SERIAL_SUB_EN (sub selects A - B via ~B + 1).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gBadWidth
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] aSr;
  logic [WIDTH-1:0] bSr;
  logic [WIDTH-1:0] sumSr;
  logic             carryQ;
  logic             aMsb;
  logic             bMsb;

  // Operand B as seen by the adder and the initial carry-in.
  logic [WIDTH-1:0] bEff;
  logic             cin0;
`ifdef SERIAL_SUB_EN
  assign bEff = bus.sub ? ~bus.B : bus.B;
  assign cin0 = bus.sub;
`else
  assign bEff = bus.B;
  assign cin0 = 1'b0;
`endif

  logic             s;
  logic             cout;
  logic [WIDTH-1:0] sumNext;

  full_adder_1bit uFa (
    .A        (aSr[0]),
    .B        (bSr[0]),
    .CarryIn  (carryQ),
    .Sum      (s),
    .CarryOut (cout)
  );

  // Result bits enter at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
  assign sumNext = {s, sumSr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      aSr          <= '0;
      bSr          <= '0;
      sumSr        <= '0;
      carryQ       <= 1'b0;
      aMsb         <= 1'b0;
      bMsb         <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.Sum      <= '0;
      bus.CarryOut <= 1'b0;
      bus.Ovfl     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            aSr      <= bus.A;
            bSr      <= bEff;
            carryQ   <= cin0;
            count    <= '0;
            aMsb     <= bus.A[WIDTH-1];
            bMsb     <= bEff[WIDTH-1];
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sumSr  <= sumNext;
          carryQ <= cout;
          aSr    <= {1'b0, aSr[WIDTH-1:1]};
          bSr    <= {1'b0, bSr[WIDTH-1:1]};
          if (count == LAST) begin
            // Publish directly from the last cell output so done and the
            // result appear together in the DONE cycle.
            state        <= DONE;
            bus.done     <= 1'b1;
            bus.Sum      <= sumNext;
            bus.CarryOut <= cout;
            bus.Ovfl     <= (aMsb == bMsb) & (sumNext[WIDTH-1] != aMsb);
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nChecks = 0;
  int   nPass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string        name;
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           doneCyc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (q.size() == 0) begin
        nChecks++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_sum"},  64'(bus.Sum),      64'(e.s));
        check({e.name, "_cout"}, 64'(bus.CarryOut), 64'(e.c));
        check({e.name, "_ovfl"}, 64'(bus.Ovfl),     64'(e.o));
        check({e.name, "_lat"},  64'(cyc),          64'(e.doneCyc));
      end
    end
  end

  task automatic issue(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sb, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
`ifdef SERIAL_SUB_EN
    bus.sub = sb;
`endif
    e.name = nm; e.s = es; e.c = ec; e.o = eo; e.doneCyc = cyc + W + 1;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef SERIAL_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (W + 2) @(negedge clk);
  endtask

  initial begin
    int busyCnt;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
`ifdef SERIAL_SUB_EN
    bus.sub = 1'b0;
`endif
    sb_unused();
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_sum",  64'(bus.Sum),  64'(0));
    check("rst_cout", 64'(bus.CarryOut), 64'(0));
    check("rst_ovfl", 64'(bus.Ovfl), 64'(0));
    rst = 1'b0;

    issue("one_plus_one", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Reset in cycle 5 of an operation discards it entirely.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 16'h1234; bus.B = 16'h0001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_before", 64'(bus.busy), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", 64'(bus.busy), 64'(0));
    check("midrun_rst_done", 64'(bus.done), 64'(0));
    check("midrun_rst_sum",  64'(bus.Sum),  64'(0));
    rst = 1'b0;

    issue("after_reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    issue("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue("8000_plus_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    issue("a5a5_plus_5a5a", 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0);

    // Starts pulsed in RUN and in DONE with new operands must be ignored.
    begin
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1; bus.A = 16'h0003; bus.B = 16'h0004;
      e.name = "ignore_start"; e.s = 16'h0007; e.c = 1'b0; e.o = 1'b0;
      e.doneCyc = cyc + W + 1;
      q.push_back(e);
      busyCnt = 0;
      for (int i = 1; i <= W + 6; i++) begin
        @(negedge clk);
        if (bus.busy === 1'b1) busyCnt++;
        bus.start = (i == 5 || i == W + 1);
        bus.A = 16'hFFFF;
        bus.B = 16'hFFFF;
      end
      bus.start = 1'b0;
      check("busy_cycles", 64'(busyCnt), 64'(W + 1));
      check("sum_held", 64'(bus.Sum), 64'(16'h0007));
      check("idle_after", 64'(bus.busy), 64'(0));
    end

`ifdef SERIAL_SUB_EN
    issue("5_minus_7", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    issue("8000_minus_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  task automatic sb_unused();
  endtask

endmodule
